c7bifu_fcl_mo: RTL and testbench

- Parametrised successor to the single-request IFU fetch control.
- Supports up to MAX_OUTSTANDING in-flight ICU requests and owns the fetch PC.
- Buffers returned instructions in a FB_DEPTH-entry fetch buffer and hands them to EXU with a valid/ready handshake.
- On except/branch/ertn it redirects the PC and discards responses belonging to stale requests.

---
 rtl/c7bifu_fcl_mo_if.sv | 40 ++++
 rtl/c7bifu_fcl_mo.sv | 180 ++++++++++++++++++
 tb/tb_c7bifu_fcl_mo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/c7bifu_fcl_mo_if.sv
// Fetch-control bus bundle: ICU request/response, EXU redirects and EXU instruction handshake.
// The IFU side uses the master modport; the ICU/EXU environment uses the slave modport.
interface c7bifu_fcl_mo_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              ifu_icu_req_ic1;
    logic [ADDR_W-1:0] ifu_icu_addr_ic1;
    logic              icu_ifu_ack_ic1;
    logic              icu_ifu_data_valid_ic2;
    logic [INST_W-1:0] icu_ifu_data_ic2;
    logic              exu_ifu_except;
    logic [ADDR_W-1:0] exu_ifu_isr_addr;
    logic              exu_ifu_ertn;
    logic [ADDR_W-1:0] exu_ifu_era_addr;
    logic              exu_ifu_branch;
    logic [ADDR_W-1:0] exu_ifu_brn_addr;
    logic              ifu_exu_valid;
    logic [INST_W-1:0] ifu_exu_inst;
    logic [ADDR_W-1:0] ifu_exu_pc;
    logic              exu_ifu_ready;

    modport master (
        output ifu_icu_req_ic1, ifu_icu_addr_ic1,
        input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
        input  exu_ifu_except, exu_ifu_isr_addr, exu_ifu_ertn, exu_ifu_era_addr,
        input  exu_ifu_branch, exu_ifu_brn_addr,
        output ifu_exu_valid, ifu_exu_inst, ifu_exu_pc,
        input  exu_ifu_ready
    );

    modport slave (
        input  ifu_icu_req_ic1, ifu_icu_addr_ic1,
        output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
        output exu_ifu_except, exu_ifu_isr_addr, exu_ifu_ertn, exu_ifu_era_addr,
        output exu_ifu_branch, exu_ifu_brn_addr,
        input  ifu_exu_valid, ifu_exu_inst, ifu_exu_pc,
        output exu_ifu_ready
    );
endinterface

// File: rtl/c7bifu_fcl_mo.sv
// Multi-outstanding IFU fetch control: owns the fetch PC, tracks in-flight ICU requests, buffers responses.
// Optional macro C7BIFU_FCL_BYPASS_EN forwards a response straight to EXU when the buffer is empty.
module c7bifu_fcl_mo #(
    parameter int                 ADDR_W          = 32,
    parameter int                 INST_W          = 32,
    parameter int                 MAX_OUTSTANDING = 2,
    parameter int                 FB_DEPTH        = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC        = ADDR_W'(32'h1C00_0000)
) (
    input  logic            clk,
    input  logic            reset,
    c7bifu_fcl_mo_if.master bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FB_AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int FBC_W = $clog2(FB_DEPTH + 1);
    localparam int SUM_W = FBC_W + CNT_W;

    function automatic logic [TQ_AW-1:0] tq_inc(input logic [TQ_AW-1:0] p);
        return (p == TQ_AW'(MAX_OUTSTANDING - 1)) ? '0 : p + TQ_AW'(1);
    endfunction

    function automatic logic [FB_AW-1:0] fb_inc(input logic [FB_AW-1:0] p);
        return (p == FB_AW'(FB_DEPTH - 1)) ? '0 : p + FB_AW'(1);
    endfunction

    logic              req_q,    req_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic              stale_q,  stale_d;
    logic [CNT_W-1:0]  out_q,    out_d;
    logic [CNT_W-1:0]  kill_q,   kill_d;
    logic [TQ_AW-1:0]  tq_wr_q,  tq_wr_d;
    logic [TQ_AW-1:0]  tq_rd_q,  tq_rd_d;
    logic [FB_AW-1:0]  fb_wr_q,  fb_wr_d;
    logic [FB_AW-1:0]  fb_rd_q,  fb_rd_d;
    logic [FBC_W-1:0]  fb_cnt_q, fb_cnt_d;

    logic [ADDR_W-1:0] tq_mem      [MAX_OUTSTANDING];
    logic [ADDR_W-1:0] fb_pc_mem   [FB_DEPTH];
    logic [INST_W-1:0] fb_inst_mem [FB_DEPTH];

    logic              flush;
    logic [ADDR_W-1:0] flush_tgt;
    logic              ack_fire;
    logic              dv_fire;
    logic              kill_hit;
    logic              keep;
    logic              byp;
    logic              issue;
    logic              fb_push;
    logic              fb_pop;
    logic              fb_nonempty;
    logic [CNT_W-1:0]  out_nxt;
    logic [ADDR_W-1:0] resp_pc;
    logic [SUM_W-1:0]  credit_used;

    assign flush     = bus.exu_ifu_except | bus.exu_ifu_ertn | bus.exu_ifu_branch;
    assign flush_tgt = bus.exu_ifu_except ? bus.exu_ifu_isr_addr :
                       bus.exu_ifu_ertn   ? bus.exu_ifu_era_addr :
                                            bus.exu_ifu_brn_addr;

    // A response with nothing in flight is a protocol error and is ignored.
    assign ack_fire    = req_q & bus.icu_ifu_ack_ic1;
    assign dv_fire     = bus.icu_ifu_data_valid_ic2 & (out_q != '0);
    assign kill_hit    = dv_fire & (kill_q != '0);
    assign keep        = dv_fire & ~kill_hit;
    assign resp_pc     = tq_mem[tq_rd_q];
    assign fb_nonempty = (fb_cnt_q != '0);
    assign out_nxt     = out_q + CNT_W'(ack_fire) - CNT_W'(dv_fire);

    // Every in-flight request already owns a buffer slot, so a response can always be pushed.
    assign credit_used = SUM_W'(fb_cnt_q) + SUM_W'(out_q);
    assign issue       = ~req_q & ~flush
                       & (out_q < CNT_W'(MAX_OUTSTANDING))
                       & (credit_used < SUM_W'(FB_DEPTH));

`ifdef C7BIFU_FCL_BYPASS_EN
    assign byp = ~fb_nonempty & keep & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign fb_pop  = fb_nonempty & bus.exu_ifu_ready;
    assign fb_push = keep & ~(byp & bus.exu_ifu_ready);

    assign bus.ifu_icu_req_ic1  = req_q;
    assign bus.ifu_icu_addr_ic1 = addr_q;
    assign bus.ifu_exu_valid    = fb_nonempty | byp;
    assign bus.ifu_exu_inst     = byp ? bus.icu_ifu_data_ic2 : fb_inst_mem[fb_rd_q];
    assign bus.ifu_exu_pc       = byp ? resp_pc : fb_pc_mem[fb_rd_q];

    always_comb begin
        req_d    = req_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        stale_d  = stale_q;
        out_d    = out_nxt;
        kill_d   = kill_q + CNT_W'(ack_fire & stale_q) - CNT_W'(kill_hit);
        tq_wr_d  = ack_fire ? tq_inc(tq_wr_q) : tq_wr_q;
        tq_rd_d  = dv_fire ? tq_inc(tq_rd_q) : tq_rd_q;
        fb_wr_d  = fb_push ? fb_inc(fb_wr_q) : fb_wr_q;
        fb_rd_d  = fb_pop ? fb_inc(fb_rd_q) : fb_rd_q;
        fb_cnt_d = fb_cnt_q;
        case ({fb_push, fb_pop})
            2'b10:   fb_cnt_d = fb_cnt_q + FBC_W'(1);
            2'b01:   fb_cnt_d = fb_cnt_q - FBC_W'(1);
            default: fb_cnt_d = fb_cnt_q;
        endcase

        if (ack_fire) begin
            req_d   = 1'b0;
            stale_d = 1'b0;
            if (!stale_q) begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = pc_q;
        end

        // Everything still in flight after this cycle belongs to the old path, including a same-cycle ack.
        if (flush) begin
            pc_d     = flush_tgt;
            kill_d   = out_nxt;
            fb_wr_d  = '0;
            fb_rd_d  = '0;
            fb_cnt_d = '0;
            if (req_q && !ack_fire) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            pc_q     <= RESET_PC;
            stale_q  <= 1'b0;
            out_q    <= '0;
            kill_q   <= '0;
            tq_wr_q  <= '0;
            tq_rd_q  <= '0;
            fb_wr_q  <= '0;
            fb_rd_q  <= '0;
            fb_cnt_q <= '0;
        end else begin
            req_q    <= req_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            stale_q  <= stale_d;
            out_q    <= out_d;
            kill_q   <= kill_d;
            tq_wr_q  <= tq_wr_d;
            tq_rd_q  <= tq_rd_d;
            fb_wr_q  <= fb_wr_d;
            fb_rd_q  <= fb_rd_d;
            fb_cnt_q <= fb_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ack_fire) begin
            tq_mem[tq_wr_q] <= addr_q;
        end
        if (fb_push) begin
            fb_inst_mem[fb_wr_q] <= bus.icu_ifu_data_ic2;
            fb_pc_mem[fb_wr_q]   <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.icu_ifu_data_valid_ic2 && (out_q == '0)))
                else $error("c7bifu_fcl_mo: data_valid with no request outstanding");
        end
    end
endmodule

// File: tb/tb_c7bifu_fcl_mo.sv
// Directed bench for c7bifu_fcl_mo: scripted ICU responder, EXU delivery log, immediate-assert checks.
`timescale 1ns/1ps
module tb_c7bifu_fcl_mo;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
`ifdef C7BIFU_FCL_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    c7bifu_fcl_mo_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    c7bifu_fcl_mo #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .MAX_OUTSTANDING(2), .FB_DEPTH(4),
        .RESET_PC(32'h1C00_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ICU responder state
    bit          ack_en = 1'b0;
    int          data_dly = 2;
    int          req_age = 0;
    int          tb_out = 0;
    int          tb_max_out = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] ack_log[$];
    logic [31:0] dv_addr_log[$];
    int          dv_cyc_log[$];

    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    // ICU model: acks a request after it has been visible one cycle, returns ~addr data_dly cycles later
    initial begin
        logic [31:0] a;
        bus.icu_ifu_ack_ic1        = 1'b0;
        bus.icu_ifu_data_valid_ic2 = 1'b0;
        bus.icu_ifu_data_ic2       = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.icu_ifu_ack_ic1        = 1'b0;
            bus.icu_ifu_data_valid_ic2 = 1'b0;
            if (!reset && bus.ifu_icu_req_ic1) begin
                if (ack_en && req_age >= 1) begin
                    bus.icu_ifu_ack_ic1 = 1'b1;
                    ack_log.push_back(bus.ifu_icu_addr_ic1);
                    pend_addr.push_back(bus.ifu_icu_addr_ic1);
                    pend_due.push_back(cyc + data_dly);
                    tb_out++;
                end
                req_age++;
            end else begin
                req_age = 0;
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                bus.icu_ifu_data_valid_ic2 = 1'b1;
                bus.icu_ifu_data_ic2       = ~a;
                dv_addr_log.push_back(a);
                dv_cyc_log.push_back(cyc);
                tb_out--;
            end
            if (tb_out > tb_max_out) tb_max_out = tb_out;
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.ifu_exu_valid && bus.exu_ifu_ready) begin
            got_pc.push_back(bus.ifu_exu_pc);
            got_inst.push_back(bus.ifu_exu_inst);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(got_pc.size()), 32'(n));
    endtask

    task automatic chk_got(input int idx, input logic [31:0] exp_pc, input string tag);
        logic [31:0] p;
        logic [31:0] ins;
        p   = (idx < got_pc.size()) ? got_pc[idx] : 32'hDEAD_DEAD;
        ins = (idx < got_inst.size()) ? got_inst[idx] : 32'hDEAD_DEAD;
        chk({tag, "_pc"}, p, exp_pc);
        chk({tag, "_inst"}, ins, ~exp_pc);
    endtask

    task automatic do_flush(input bit e, input bit r, input bit b, input logic [31:0] isr,
                            input logic [31:0] era, input logic [31:0] brn, output int nb);
        bus.exu_ifu_except   = e;
        bus.exu_ifu_ertn     = r;
        bus.exu_ifu_branch   = b;
        bus.exu_ifu_isr_addr = isr;
        bus.exu_ifu_era_addr = era;
        bus.exu_ifu_brn_addr = brn;
        bus.exu_ifu_ready    = 1'b0;
        nb = got_pc.size();
        tick(1);
        bus.exu_ifu_except = 1'b0;
        bus.exu_ifu_ertn   = 1'b0;
        bus.exu_ifu_branch = 1'b0;
    endtask

    initial begin
        int nb;
        int k;
        int n_ack;
        int vcyc;
        int dcyc;
        logic [31:0] held_addr;

        bus.exu_ifu_except   = 1'b0;
        bus.exu_ifu_ertn     = 1'b0;
        bus.exu_ifu_branch   = 1'b0;
        bus.exu_ifu_isr_addr = '0;
        bus.exu_ifu_era_addr = '0;
        bus.exu_ifu_brn_addr = '0;
        bus.exu_ifu_ready    = 1'b0;

        // reset for three cycles, then the first request appears one cycle later
        tick(3);
        chk("rst_req", 32'(bus.ifu_icu_req_ic1), 32'd0);
        chk("rst_valid", 32'(bus.ifu_exu_valid), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("first_req", 32'(bus.ifu_icu_req_ic1), 32'd1);
        chk("first_addr", bus.ifu_icu_addr_ic1, 32'h1C00_0000);
        ack_en = 1'b1;

        // EXU stalled: exactly FB_DEPTH instructions fetched, then fetch stops
        tick(40);
        chk("full_acks", 32'(ack_log.size()), 32'd4);
        chk("full_req", 32'(bus.ifu_icu_req_ic1), 32'd0);
        chk("full_valid", 32'(bus.ifu_exu_valid), 32'd1);
        chk("full_head_pc", bus.ifu_exu_pc, 32'h1C00_0000);

        bus.exu_ifu_ready = 1'b1;
        wait_got(5, 100, "drain_cnt");
        for (int i = 0; i < 5; i++) chk_got(i, 32'h1C00_0000 + 32'(4 * i), "seq");

        // branch with two requests in flight
        data_dly = 6;
        k = 0;
        while (tb_out != 2 && k < 100) begin
            tick(1);
            k++;
        end
        chk("out_two", 32'(tb_out), 32'd2);
        do_flush(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1C00_0100, nb);
        chk("brn_empty", 32'(bus.ifu_exu_valid), 32'd0);
        bus.exu_ifu_ready = 1'b1;
        wait_got(nb + 2, 150, "brn_cnt");
        chk_got(nb, 32'h1C00_0100, "brn0");
        chk_got(nb + 1, 32'h1C00_0104, "brn1");
        chk("max_out", 32'(tb_max_out), 32'd2);

        // redirect priority
        tick(3);
        do_flush(1'b1, 1'b1, 1'b1, 32'h1C00_0800, 32'h1C00_0400, 32'h1C00_0100, nb);
        bus.exu_ifu_ready = 1'b1;
        wait_got(nb + 1, 150, "exc_cnt");
        chk_got(nb, 32'h1C00_0800, "exc");

        tick(2);
        do_flush(1'b0, 1'b1, 1'b1, 32'h0, 32'h1C00_0400, 32'h1C00_0100, nb);
        bus.exu_ifu_ready = 1'b1;
        wait_got(nb + 1, 150, "ertn_cnt");
        chk_got(nb, 32'h1C00_0400, "ertn");

        // flush while a request is pending and not yet acked
        ack_en = 1'b0;
        k = 0;
        while (!bus.ifu_icu_req_ic1 && k < 60) begin
            tick(1);
            k++;
        end
        chk("pend_req_seen", 32'(bus.ifu_icu_req_ic1), 32'd1);
        held_addr = bus.ifu_icu_addr_ic1;
        do_flush(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1C00_0200, nb);
        chk("pend_req_hold", 32'(bus.ifu_icu_req_ic1), 32'd1);
        chk("pend_addr_hold", bus.ifu_icu_addr_ic1, held_addr);
        n_ack = ack_log.size();
        ack_en = 1'b1;
        bus.exu_ifu_ready = 1'b1;
        wait_got(nb + 1, 150, "pend_cnt");
        chk_got(nb, 32'h1C00_0200, "pend");
        chk("pend_ack0", (ack_log.size() > n_ack) ? ack_log[n_ack] : 32'hDEAD_DEAD, held_addr);
        chk("pend_ack1", (ack_log.size() > n_ack + 1) ? ack_log[n_ack + 1] : 32'hDEAD_DEAD,
            32'h1C00_0200);

        // wrap-around and empty-buffer latency
        tick(2);
        do_flush(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFF8, nb);
        vcyc = -100;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.ifu_exu_valid) begin
                vcyc = cyc;
                break;
            end
        end
        chk("wrap_head", bus.ifu_exu_pc, 32'hFFFF_FFF8);
        dcyc = -1000;
        for (int i = dv_addr_log.size() - 1; i >= 0; i--) begin
            if (dv_addr_log[i] == 32'hFFFF_FFF8) begin
                dcyc = dv_cyc_log[i];
                break;
            end
        end
        chk("empty_latency", 32'(vcyc - dcyc), 32'(LAT));
        @(posedge clk);
        #1;
        bus.exu_ifu_ready = 1'b1;
        wait_got(nb + 3, 150, "wrap_cnt");
        chk_got(nb, 32'hFFFF_FFF8, "wrap0");
        chk_got(nb + 1, 32'hFFFF_FFFC, "wrap1");
        chk_got(nb + 2, 32'h0000_0000, "wrap2");

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
